display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clk cycles each digit stays enabled (DIV >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load  input  1  single-cycle request to capture value/neg/dec_mode.
REQ-005 SHALL have port value  input  16  unsigned magnitude to display.
REQ-006 SHALL have port neg  input  1  sign flag captured with value.
REQ-007 SHALL have port dec_mode  input  1  1 = decimal display, 0 = hexadecimal display.
REQ-008 SHALL have port bcd  output  5  code of currently enabled digit, feeding the downstream seven-segment decoder; 5'h1F = blank.
REQ-009 SHALL have port an  output  4  digit enables, active-low, one-hot-zero.
REQ-010 SHALL have port sign  output  1  latched neg, feeding the decoder sign input.
REQ-011 SHALL have port busy  output  1  decimal conversion in progress.
REQ-012 SHALL have port ready  output  1  one-cycle pulse when display registers take a new value.
REQ-013 SHALL have port ovf  output  1  latched: last decimal value exceeded 9999.

Function
REQ-014 SHALL hold four 4-bit display digits d3..d0 (d0 least significant, rightmost) plus latched sign and mode.
REQ-015 SHALL implement FSM states IDLE and CONV; load is honoured only in IDLE, ignored in CONV.
REQ-016 Hex load (IDLE, load=1, dec_mode=0): next edge sets d3..d0 = value[15:0] nibbles, sign=neg, ovf=0, ready=1 for that one cycle; stays IDLE.
REQ-017 Decimal load (IDLE, load=1, dec_mode=1): next edge captures operand (min(value,9999)), ovf=(value>9999), neg, enters CONV, busy=1.
REQ-018 CONV SHALL run a sequential shift-add-3 binary-to-BCD conversion, one bit per cycle, exactly 16 cycles in CONV.
REQ-019 On edge ending the 16th iteration: d3..d0 = BCD result, sign updated, busy=0, ready=1 for one cycle, return to IDLE.
REQ-020 Display registers SHALL keep previous contents throughout CONV (no partial results visible).
REQ-021 Prescaler SHALL count 0..DIV-1 and wrap; at DIV-1 digit index advances 0->1->2->3->0.
REQ-022 an SHALL be 4'b1110, 4'b1101, 4'b1011, 4'b0111 for index 0,1,2,3.
REQ-023 bcd SHALL be {1'b0, d[index]} registered-consistent with an (same cycle), except blanking.
REQ-024 Decimal mode leading-zero blanking: digit k>0 shows 5'h1F when d_k and all higher digits are zero; d0 never blanked; hex mode never blanks.
REQ-025 Scanning SHALL run continuously, unaffected by load, busy, or FSM state.
REQ-026 ready and busy SHALL never be high in the same cycle.

Reset
REQ-027 rst low SHALL immediately force: state IDLE, busy=0, ready=0, ovf=0, sign=0, d3..d0=0, mode=hex, prescaler=0, index=0, an=4'b1110, bcd=5'h00.
REQ-028 Reset during CONV SHALL abort conversion with no ready pulse; first load after release is honoured normally.

Verification (DIV=4)
REQ-029 Hex: load value=16'hA3F1, neg=1 -> next cycle ready=1, sign=1; over 16 cycles bcd sequence 01,0F,03,0A with an 1110,1101,1011,0111.
REQ-030 Decimal: load value=16'd1234 -> busy high exactly 16 cycles, then ready pulse, digits scan 04,03,02,01, ovf=0.
REQ-031 Blanking/overflow: load dec value=7 -> scan 07,1F,1F,1F; then load dec value=16'd12000 -> digits 9,9,9,9, ovf=1.
REQ-032 Load during CONV: second load at busy cycle 5 with value=16'd42 -> ignored; result equals first operand, single ready pulse.
REQ-033 Reset mid-CONV at busy cycle 8 -> an=4'b1110, bcd=00, busy=0, no ready; subsequent dec load of 16'd9999 -> 9,9,9,9, ovf=0.
REQ-034 Scan continuity: 40 cycles with no load -> an rotates every 4 cycles, exact one-hot-low pattern, no glitch cycle with two digits enabled.

Source files
------------

// File: rtl/display_scan.sv
// Four-digit multiplexed display driver with hex or
// sequential binary-to-BCD decimal presentation.
module display_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        neg,
  input  logic        dec_mode,
  output logic [4:0]  bcd,
  output logic [3:0]  an,
  output logic        sign,
  output logic        busy,
  output logic        ready,
  output logic        ovf
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, nxt;
  logic [15:0] d;
  logic        mode;
  logic        sign_p;
  logic [15:0] opnd;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [15:0] acc_n;
  logic [3:0]  cnt;
  logic        last;
  logic [PW-1:0] presc;
  logic [1:0]  idx;
  logic [3:0]  dig;
  logic        blank;

  assign last = (cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (load && dec_mode) nxt = CONV;
      CONV: if (last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < 4; k++) begin
      if (acc[4*k +: 4] >= 4'd5)
        acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
    acc_n = {acc_adj[14:0], opnd[15]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d      <= '0;
      mode   <= 1'b0;
      sign   <= 1'b0;
      sign_p <= 1'b0;
      ovf    <= 1'b0;
      ready  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load && dec_mode) begin
            opnd   <= (value > 16'd9999) ? 16'd9999 : value;
            ovf    <= (value > 16'd9999);
            sign_p <= neg;
            acc    <= '0;
            cnt    <= '0;
          end else if (load) begin
            d     <= value;
            sign  <= neg;
            mode  <= 1'b0;
            ovf   <= 1'b0;
            ready <= 1'b1;
          end
        end
        CONV: begin
          acc  <= acc_n;
          opnd <= {opnd[14:0], 1'b0};
          cnt  <= cnt + 4'd1;
          if (last) begin
            d     <= acc_n;
            sign  <= sign_p;
            mode  <= 1'b1;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PMAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    an = 4'b1111;
    blank = 1'b0;
    unique case (1'b1)
      (idx == 2'd0): begin
        an  = 4'b1110;
        dig = d[3:0];
      end
      (idx == 2'd1): begin
        an    = 4'b1101;
        dig   = d[7:4];
        blank = (d[15:4] == 12'd0);
      end
      (idx == 2'd2): begin
        an    = 4'b1011;
        dig   = d[11:8];
        blank = (d[15:8] == 8'd0);
      end
      default: begin
        an    = 4'b0111;
        dig   = d[15:12];
        blank = (d[15:12] == 4'd0);
      end
    endcase
    bcd = (mode && blank) ? 5'h1F : {1'b0, dig};
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan at DIV=4: load table
// plus reset-abort, ignored-load and scan-continuity runs.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        neg = 1'b0;
  logic        dec_mode = 1'b0;
  logic [4:0]  bcd;
  logic [3:0]  an;
  logic        sign, busy, ready, ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  display_scan #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load),
    .value(value), .neg(neg), .dec_mode(dec_mode),
    .bcd(bcd), .an(an), .sign(sign),
    .busy(busy), .ready(ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // edges since reset release; scan index = (cyc/4)%4
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic        dec;
    logic [15:0] val;
    logic        neg;
    logic [19:0] codes;
    logic        sgn;
    logic        ovf;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_scan(input string nm,
                          input logic [19:0] codes,
                          input int n);
    int k;
    logic [3:0] ea;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k = (cyc / 4) % 4;
      ea = ~(4'b0001 << k);
      chk({nm, "_an"}, an, ea);
      chk({nm, "_bcd"}, bcd, codes[k*5 +: 5]);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    value = v.val;
    neg = v.neg;
    dec_mode = v.dec;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (!v.dec) begin
      chk({nm, "_ready"}, ready, 1);
      chk({nm, "_busy"}, busy, 0);
    end else begin
      n = 0;
      while (busy && n < 40) begin
        chk({nm, "_rdy_in_busy"}, ready, 0);
        n++;
        @(negedge clk);
      end
      chk({nm, "_busy_len"}, n, 16);
      chk({nm, "_ready"}, ready, 1);
    end
    chk({nm, "_sign"}, sign, v.sgn);
    chk({nm, "_ovf"}, ovf, v.ovf);
    @(negedge clk);
    chk({nm, "_ready_pulse"}, ready, 0);
    chk_scan(nm, v.codes, 16);
  endtask

  initial begin
    int n;
    int rdy;
    vec_t w;

    tv[0] = '{1'b0, 16'hA3F1, 1'b1,
              {5'h0A, 5'h03, 5'h0F, 5'h01}, 1'b1, 1'b0};
    tv[1] = '{1'b1, 16'd1234, 1'b0,
              {5'h01, 5'h02, 5'h03, 5'h04}, 1'b0, 1'b0};
    tv[2] = '{1'b1, 16'd7, 1'b0,
              {5'h1F, 5'h1F, 5'h1F, 5'h07}, 1'b0, 1'b0};
    tv[3] = '{1'b1, 16'd12000, 1'b0,
              {5'h09, 5'h09, 5'h09, 5'h09}, 1'b0, 1'b1};
    tv[4] = '{1'b0, 16'h0000, 1'b0,
              {5'h00, 5'h00, 5'h00, 5'h00}, 1'b0, 1'b0};
    tv[5] = '{1'b1, 16'd0, 1'b1,
              {5'h1F, 5'h1F, 5'h1F, 5'h00}, 1'b1, 1'b0};
    tv[6] = '{1'b1, 16'd9999, 1'b0,
              {5'h09, 5'h09, 5'h09, 5'h09}, 1'b0, 1'b0};
    tv[7] = '{1'b1, 16'd10000, 1'b1,
              {5'h09, 5'h09, 5'h09, 5'h09}, 1'b1, 1'b1};
    tv[8] = '{1'b0, 16'h00F0, 1'b0,
              {5'h00, 5'h00, 5'h0F, 5'h00}, 1'b0, 1'b0};
    tv[9] = '{1'b1, 16'd305, 1'b0,
              {5'h1F, 5'h03, 5'h00, 5'h05}, 1'b0, 1'b0};

    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_bcd", bcd, 5'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sign", sign, 0);
    @(negedge clk);
    rst = 1'b1;
    chk_scan("post_rst", 20'h0, 8);

    for (int i = 0; i < 10; i++)
      apply(tv[i], $sformatf("vec%0d", i));

    // load while converting must be ignored
    @(negedge clk);
    value = 16'd567;
    neg = 1'b0;
    dec_mode = 1'b1;
    load = 1'b1;
    rdy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 4) begin
        load = 1'b1;
        value = 16'd42;
      end else begin
        load = 1'b0;
      end
      rdy += ready;
    end
    chk("ign_ready_cnt", rdy, 1);
    chk("ign_ovf", ovf, 0);
    chk_scan("ign", {5'h1F, 5'h05, 5'h06, 5'h07}, 16);

    // reset at busy cycle 8 aborts conversion
    @(negedge clk);
    value = 16'd4321;
    neg = 1'b1;
    dec_mode = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 1;
    while (n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_an", an, 4'b1110);
    chk("abort_bcd", bcd, 5'h00);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    chk("abort_sign", sign, 0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy += ready;
      rdy += busy;
    end
    chk("abort_no_ready", rdy, 0);
    w = '{1'b1, 16'd9999, 1'b0,
          {5'h09, 5'h09, 5'h09, 5'h09}, 1'b0, 1'b0};
    apply(w, "after_abort");

    chk_scan("scan40", {5'h09, 5'h09, 5'h09, 5'h09}, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
